// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register sequencer and the i2c_ctrl write controller.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_DATA,
        ST_DECODE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_DELAY,
        ST_FINISH,
        ST_FAIL
    } seq_state_e;

    localparam logic [15:0] ENTRY_END       = 16'hFFFF;
    localparam logic [7:0]  ENTRY_DELAY_TAG = 8'hFE;

    // Worst-case i2c_ctrl write transaction is ~120 strobes; the timeout must exceed it.
    localparam int unsigned I2C_TXN_STROBES         = 120;
    localparam int unsigned DEFAULT_TIMEOUT_STROBES = 200;

endpackage

// File: rtl/i2c_strobe_timer.sv
// Loadable down-counter advanced by the 100 kHz strobe; saturates at zero.
module i2c_strobe_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         areset_n,
    input  logic         strobe,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         zero_c
);

    logic [W-1:0] count;

    // A load wins over a coincident strobe.
    always_ff @(posedge clk) begin
        if (!areset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (strobe && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Walks a ROM table of 16-bit entries and issues each one to i2c_ctrl as a register write,
// with delay entries, end-of-table detection and timeout-based retry/abort.
module i2c_reg_sequencer
    import i2c_pkg::*;
#(
    parameter int unsigned TBL_AW          = 8,
    parameter logic [6:0]  SLAVE_ADDR      = 7'h3C,
    parameter int unsigned TIMEOUT_STROBES = DEFAULT_TIMEOUT_STROBES,
    parameter int unsigned MAX_RETRY       = 2,
    parameter int unsigned DELAY_UNIT      = 100
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic              strobe_100kHz,
    input  logic              start,
    output logic              busy,
    output logic              seq_done,
    output logic              seq_error,
    output logic [TBL_AW-1:0] err_index,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [15:0]       tbl_data,
    output logic              enable,
    output logic [6:0]        slave_address,
    output logic [15:0]       register_address,
    input  logic              register_done
);

    localparam int unsigned TO_W  = $clog2(TIMEOUT_STROBES + 1);
    localparam int unsigned DLY_W = 8 + $clog2(DELAY_UNIT);
    localparam int unsigned TMR_W = (TO_W > DLY_W) ? TO_W : DLY_W;
    localparam int unsigned RTY_W = $clog2(MAX_RETRY + 2);
    localparam logic [TBL_AW-1:0] LAST_INDEX = '1;

    seq_state_e        state, state_nxt;
    logic [TBL_AW-1:0] index, index_nxt;
    logic [RTY_W-1:0]  retry, retry_nxt;
    logic [15:0]       entry, entry_nxt;
    logic              done_q;
    logic              busy_nxt, seq_done_nxt, seq_error_nxt, enable_nxt;
    logic [TBL_AW-1:0] err_index_nxt, tbl_addr_nxt;
    logic [15:0]       register_address_nxt;
    logic              tmr_load_c;
    logic [TMR_W-1:0]  tmr_value_c;
    logic              tmr_zero_c;
    logic              done_rise_c;
    logic              last_c;

    assign slave_address = SLAVE_ADDR;
    // i2c_ctrl drops register_done after enable, so only a fresh rising edge means completion.
    assign done_rise_c   = register_done && !done_q;
    assign last_c        = (index == LAST_INDEX);

    // Timeout and delay are never active together, so one timer serves both.
    i2c_strobe_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .areset_n   (areset_n),
        .strobe     (strobe_100kHz),
        .load       (tmr_load_c),
        .load_value (tmr_value_c),
        .zero_c     (tmr_zero_c)
    );

    always_ff @(posedge clk) begin
        if (!areset_n) begin
            state            <= ST_IDLE;
            index            <= '0;
            retry            <= '0;
            entry            <= '0;
            done_q           <= 1'b0;
            busy             <= 1'b0;
            seq_done         <= 1'b0;
            seq_error        <= 1'b0;
            err_index        <= '0;
            tbl_addr         <= '0;
            enable           <= 1'b0;
            register_address <= '0;
        end else begin
            state            <= state_nxt;
            index            <= index_nxt;
            retry            <= retry_nxt;
            entry            <= entry_nxt;
            done_q           <= register_done;
            busy             <= busy_nxt;
            seq_done         <= seq_done_nxt;
            seq_error        <= seq_error_nxt;
            err_index        <= err_index_nxt;
            tbl_addr         <= tbl_addr_nxt;
            enable           <= enable_nxt;
            register_address <= register_address_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (start) state_nxt = ST_FETCH;
            ST_FETCH:     state_nxt = ST_WAIT_DATA;
            ST_WAIT_DATA: state_nxt = ST_DECODE;
            ST_DECODE: begin
                if (entry == ENTRY_END)                 state_nxt = ST_FINISH;
                else if (entry[15:8] == ENTRY_DELAY_TAG) state_nxt = ST_DELAY;
                else                                    state_nxt = ST_ISSUE;
            end
            ST_ISSUE:     state_nxt = ST_WAIT_DONE;
            // Completion takes priority over a timeout expiring in the same clk.
            ST_WAIT_DONE: begin
                if (done_rise_c) begin
                    state_nxt = last_c ? ST_FINISH : ST_FETCH;
                end else if (tmr_zero_c) begin
                    state_nxt = (retry < RTY_W'(MAX_RETRY)) ? ST_ISSUE : ST_FAIL;
                end
            end
            ST_DELAY:     if (tmr_zero_c) state_nxt = last_c ? ST_FINISH : ST_FETCH;
            ST_FINISH:    state_nxt = ST_IDLE;
            ST_FAIL:      state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        index_nxt            = index;
        retry_nxt            = retry;
        entry_nxt            = entry;
        tbl_addr_nxt         = tbl_addr;
        register_address_nxt = register_address;
        seq_error_nxt        = seq_error;
        err_index_nxt        = err_index;
        busy_nxt             = !(state_nxt inside {ST_IDLE, ST_FINISH, ST_FAIL});
        enable_nxt           = (state_nxt == ST_ISSUE);
        seq_done_nxt         = (state_nxt == ST_FINISH);
        tmr_load_c           = 1'b0;
        tmr_value_c          = '0;
        case (state)
            ST_IDLE: begin
                if (state_nxt == ST_FETCH) begin
                    index_nxt     = '0;
                    retry_nxt     = '0;
                    seq_error_nxt = 1'b0;
                    tbl_addr_nxt  = '0;
                end
            end
            ST_WAIT_DATA: entry_nxt = tbl_data;
            ST_DECODE: begin
                if (state_nxt == ST_DELAY) begin
                    tmr_load_c  = 1'b1;
                    tmr_value_c = TMR_W'(entry[7:0]) * TMR_W'(DELAY_UNIT);
                end
                if (state_nxt == ST_ISSUE) register_address_nxt = entry;
            end
            ST_ISSUE: begin
                tmr_load_c  = 1'b1;
                tmr_value_c = TMR_W'(TIMEOUT_STROBES);
            end
            ST_WAIT_DONE, ST_DELAY: begin
                if (state_nxt == ST_FETCH) begin
                    index_nxt    = index + TBL_AW'(1);
                    tbl_addr_nxt = index + TBL_AW'(1);
                    retry_nxt    = '0;
                end
                if (state_nxt == ST_ISSUE) retry_nxt = retry + RTY_W'(1);
                if (state_nxt == ST_FAIL) begin
                    seq_error_nxt = 1'b1;
                    err_index_nxt = index;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Bench for i2c_reg_sequencer: ROM and i2c_ctrl models, table vectors, random tables and corner sequences.
module tb_i2c_reg_sequencer;

    localparam int unsigned MAX_RETRY = 2;
    localparam int unsigned TIMEOUT   = 200;
    localparam int unsigned LIMIT     = 30000;

    logic        clk = 1'b0;
    logic        areset_n = 1'b0;
    logic        strobe = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        busy_a, seq_done_a, seq_error_a, enable_a;
    logic [7:0]  err_index_a, tbl_addr_a;
    logic [15:0] tbl_data_a, register_address_a;
    logic [6:0]  slave_address_a;
    logic        register_done_a = 1'b0;
    logic        busy_b, seq_done_b, seq_error_b, enable_b;
    logic [1:0]  err_index_b, tbl_addr_b;
    logic [15:0] tbl_data_b, register_address_b;
    logic [6:0]  slave_address_b;
    logic        register_done_b = 1'b0;

    logic [15:0] rom [256];
    int          nack_cfg [256];
    int          nack_left [256];
    logic [15:0] iss_a [$];
    logic [15:0] iss_b [$];
    int          en_stamp [$];
    int          strobe_total = 0, sdiv = 0, pend_a = 0, pend_b = 0;
    int          done_cnt_a = 0, done_cnt_b = 0, start_stamp = 0;
    int          n_pass = 0, n_total = 0;

    logic [15:0] exp_q [$];
    int          exp_done, exp_err, exp_idx;

    typedef struct packed {
        logic [15:0] e0, e1, e2, e3;
        logic [7:0]  n0, n1, n2, n3;
        logic [7:0]  exp_n;
        logic        exp_done;
        logic        exp_err;
        logic [7:0]  exp_idx;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    i2c_reg_sequencer #(.TBL_AW(8)) dut_a (
        .clk (clk), .areset_n (areset_n), .strobe_100kHz (strobe), .start (start_a),
        .busy (busy_a), .seq_done (seq_done_a), .seq_error (seq_error_a), .err_index (err_index_a),
        .tbl_addr (tbl_addr_a), .tbl_data (tbl_data_a), .enable (enable_a),
        .slave_address (slave_address_a), .register_address (register_address_a),
        .register_done (register_done_a)
    );

    i2c_reg_sequencer #(.TBL_AW(2)) dut_b (
        .clk (clk), .areset_n (areset_n), .strobe_100kHz (strobe), .start (start_b),
        .busy (busy_b), .seq_done (seq_done_b), .seq_error (seq_error_b), .err_index (err_index_b),
        .tbl_addr (tbl_addr_b), .tbl_data (tbl_data_b), .enable (enable_b),
        .slave_address (slave_address_b), .register_address (register_address_b),
        .register_done (register_done_b)
    );

    // Registered ROM: data appears one clk after the address changes.
    always @(posedge clk) begin
        tbl_data_a <= rom[tbl_addr_a];
        tbl_data_b <= rom[8'(tbl_addr_b)];
    end

    // Strobe generator plus i2c_ctrl models (ACK after a random latency, or stay silent on NACK).
    always @(negedge clk) begin
        sdiv   = (sdiv == 3) ? 0 : sdiv + 1;
        strobe = (sdiv == 0);
        if (strobe) strobe_total++;
        if (seq_done_a) done_cnt_a++;
        if (seq_done_b) done_cnt_b++;
        if (enable_a) begin
            iss_a.push_back(register_address_a);
            en_stamp.push_back(strobe_total);
            register_done_a = 1'b0;
            if (nack_left[tbl_addr_a] > 0) begin
                nack_left[tbl_addr_a]--;
                pend_a = 0;
            end else begin
                pend_a = int'($urandom_range(3, 40));
            end
        end else if (strobe && pend_a > 0) begin
            pend_a--;
            if (pend_a == 0) register_done_a = 1'b1;
        end
        if (enable_b) begin
            iss_b.push_back(register_address_b);
            register_done_b = 1'b0;
            pend_b = 5;
        end else if (strobe && pend_b > 0) begin
            pend_b--;
            if (pend_b == 0) register_done_b = 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    endtask

    task automatic chk_range(input string nm, input int act, input int lo, input int hi);
        n_total++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    endtask

    // Reference: walk the table by its rules, listing every write the controller should see.
    function automatic void model_run(input int aw);
        logic [15:0] e;
        int fails;
        exp_q.delete();
        exp_done = 1; exp_err = 0; exp_idx = 0;
        for (int idx = 0; idx < (1 << aw); idx++) begin
            e = rom[idx];
            if (e == 16'hFFFF) return;
            if (e[15:8] != 8'hFE) begin
                fails = nack_cfg[idx];
                if (fails > int'(MAX_RETRY)) begin
                    for (int k = 0; k <= int'(MAX_RETRY); k++) exp_q.push_back(e);
                    exp_done = 0; exp_err = 1; exp_idx = idx;
                    return;
                end
                for (int k = 0; k <= fails; k++) exp_q.push_back(e);
            end
        end
    endfunction

    task automatic load_tbl(input logic [15:0] e0, e1, e2, e3, input int n0, n1, n2, n3);
        for (int i = 0; i < 256; i++) begin rom[i] = 16'hFFFF; nack_cfg[i] = 0; end
        rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3;
        nack_cfg[0] = n0; nack_cfg[1] = n1; nack_cfg[2] = n2; nack_cfg[3] = n3;
    endtask

    task automatic run_a(input string nm);
        int cyc;
        iss_a.delete(); en_stamp.delete(); done_cnt_a = 0;
        for (int i = 0; i < 256; i++) nack_left[i] = nack_cfg[i];
        model_run(8);
        @(negedge clk); start_a = 1'b1; start_stamp = strobe_total;
        @(negedge clk); start_a = 1'b0;
        cyc = 0;
        while (busy_a && cyc < int'(LIMIT)) begin @(negedge clk); cyc++; end
        chk({nm, " ends within bound"}, int'(cyc < int'(LIMIT)), 1);
        repeat (2) @(negedge clk);
        chk({nm, " enable count"}, iss_a.size(), exp_q.size());
        for (int i = 0; i < iss_a.size() && i < exp_q.size(); i++)
            chk($sformatf("%s write %0d", nm, i), int'(iss_a[i]), int'(exp_q[i]));
        chk({nm, " seq_done pulses"}, done_cnt_a, exp_done);
        chk({nm, " seq_error"}, int'(seq_error_a), exp_err);
        if (exp_err != 0) chk({nm, " err_index"}, int'(err_index_a), exp_idx);
        chk({nm, " busy idle"}, int'(busy_a), 0);
    endtask

    function automatic vec_t mk_vec(input logic [15:0] e0, e1, e2, e3, input logic [7:0] n0, n1, n2, n3,
                                    input logic [7:0] en, input logic ed, input logic ee, input logic [7:0] ei);
        vec_t v;
        v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
        v.n0 = n0; v.n1 = n1; v.n2 = n2; v.n3 = n3;
        v.exp_n = en; v.exp_done = ed; v.exp_err = ee; v.exp_idx = ei;
        return v;
    endfunction

    initial begin
        int cyc, len, n_before;
        logic [15:0] v;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset busy", int'(busy_a), 0);
        chk("reset enable", int'(enable_a), 0);
        chk("reset tbl_addr", int'(tbl_addr_a), 0);
        chk("reset register_address", int'(register_address_a), 0);
        chk("reset seq_error", int'(seq_error_a), 0);
        chk("reset seq_done", int'(seq_done_a), 0);
        chk("reset err_index", int'(err_index_a), 0);
        chk("slave_address", int'(slave_address_a), 'h3C);
        chk("slave_address b", int'(slave_address_b), 'h3C);
        areset_n = 1'b1;

        vecs[0] = mk_vec(16'h1234, 16'hABCD, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0, 2, 1, 0, 0);
        vecs[1] = mk_vec(16'h1111, 16'h2222, 16'hFFFF, 16'hFFFF, 9, 0, 0, 0, 3, 0, 1, 0);
        vecs[2] = mk_vec(16'h1111, 16'h2222, 16'h3333, 16'hFFFF, 0, 1, 0, 0, 4, 1, 0, 0);
        vecs[3] = mk_vec(16'hFE00, 16'h4444, 16'hFE00, 16'hFFFF, 0, 0, 0, 0, 1, 1, 0, 0);
        vecs[4] = mk_vec(16'hFFFF, 16'h1234, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0, 0, 1, 0, 0);
        vecs[5] = mk_vec(16'h5555, 16'h6666, 16'h7777, 16'hFFFF, 0, 0, 3, 0, 5, 0, 1, 2);

        for (int i = 0; i < 6; i++) begin
            load_tbl(vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3,
                     int'(vecs[i].n0), int'(vecs[i].n1), int'(vecs[i].n2), int'(vecs[i].n3));
            run_a($sformatf("vec%0d", i));
            chk($sformatf("vec%0d table enables", i), iss_a.size(), int'(vecs[i].exp_n));
            chk($sformatf("vec%0d table done", i), done_cnt_a, int'(vecs[i].exp_done));
            chk($sformatf("vec%0d table error", i), int'(seq_error_a), int'(vecs[i].exp_err));
            chk($sformatf("vec%0d table err_index", i), int'(err_index_a) * int'(vecs[i].exp_err),
                int'(vecs[i].exp_idx));
        end

        // Always-NACKed entry 0: three enables, each a full timeout apart
        load_tbl(16'h1234, 16'h5678, 16'hFFFF, 16'hFFFF, 9, 0, 0, 0);
        run_a("nack");
        if (en_stamp.size() == 3) begin
            chk_range("nack spacing 0-1", en_stamp[1] - en_stamp[0], TIMEOUT - 1, TIMEOUT + 2);
            chk_range("nack spacing 1-2", en_stamp[2] - en_stamp[1], TIMEOUT - 1, TIMEOUT + 2);
        end else begin
            chk("nack stamp count", en_stamp.size(), 3);
        end

        // Delay entry of 3 ticks ahead of a write
        load_tbl(16'hFE03, 16'h5566, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0);
        run_a("delay");
        if (en_stamp.size() > 0) begin
            chk_range("delay strobes before enable", en_stamp[0] - start_stamp, 299, 304);
            chk("delay register_address", int'(iss_a[0]), 'h5566);
        end else begin
            chk("delay enable seen", 0, 1);
        end

        // Random tables against the reference model
        for (int r = 0; r < 6; r++) begin
            len = int'($urandom_range(1, 6));
            load_tbl(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 9) == 0) begin
                    rom[i] = {8'hFE, 7'd0, 1'($urandom_range(0, 1))};
                end else begin
                    v = 16'($urandom);
                    v[15:8] = 8'($urandom_range(0, 253));
                    rom[i] = v;
                    nack_cfg[i] = ($urandom_range(0, 9) < 8) ? 0 : int'($urandom_range(1, 3));
                end
            end
            run_a($sformatf("rand%0d", r));
        end

        // start while busy is ignored; reset during WAIT_DONE abandons the transaction
        load_tbl(16'h1111, 16'h2222, 16'hFFFF, 16'hFFFF, 0, 99, 0, 0);
        iss_a.delete();
        for (int i = 0; i < 256; i++) nack_left[i] = nack_cfg[i];
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        cyc = 0;
        while (iss_a.size() < 2 && cyc < int'(LIMIT)) begin @(negedge clk); cyc++; end
        chk("busy-start reached entry 1", iss_a.size(), 2);
        repeat (20) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (10) @(negedge clk);
        chk("busy-start tbl_addr kept", int'(tbl_addr_a), 1);
        chk("busy-start no new enable", iss_a.size(), 2);
        chk("busy-start still busy", int'(busy_a), 1);
        n_before = iss_a.size();
        areset_n = 1'b0;
        @(negedge clk);
        chk("mid reset busy", int'(busy_a), 0);
        chk("mid reset enable", int'(enable_a), 0);
        chk("mid reset tbl_addr", int'(tbl_addr_a), 0);
        chk("mid reset register_address", int'(register_address_a), 0);
        chk("mid reset seq_error", int'(seq_error_a), 0);
        areset_n = 1'b1;
        repeat (1000) @(negedge clk);
        chk("post reset no enable", iss_a.size(), n_before);
        chk("post reset idle", int'(busy_a), 0);

        // Four-entry table without terminator ends after the last entry
        load_tbl(16'h0101, 16'h0202, 16'hFE00, 16'h0404, 0, 0, 0, 0);
        model_run(2);
        iss_b.delete(); done_cnt_b = 0;
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        cyc = 0;
        while (busy_b && cyc < int'(LIMIT)) begin @(negedge clk); cyc++; end
        chk("aw2 ends within bound", int'(cyc < int'(LIMIT)), 1);
        repeat (2) @(negedge clk);
        chk("aw2 enable count", iss_b.size(), 3);
        for (int i = 0; i < iss_b.size() && i < exp_q.size(); i++)
            chk($sformatf("aw2 write %0d", i), int'(iss_b[i]), int'(exp_q[i]));
        chk("aw2 seq_done pulses", done_cnt_b, 1);
        chk("aw2 seq_error", int'(seq_error_b), 0);
        chk("aw2 tbl_addr at end", int'(tbl_addr_b), 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/i2c_reg_sequencer.md
Name: i2c_reg_sequencer

Overview:
- Upstream command source for the I2C write controller (`i2c_ctrl`).
- Walks a table of 16-bit entries held in an external ROM, one entry per I2C write transaction, and issues each entry through the controller's `enable` / `register_address` / `register_done` interface.
- Provides delay entries, end-of-table detection, NACK/timeout detection with bounded retries, and a start/busy/done/error interface for the system boot FSM.
- Sits between the boot FSM and `i2c_ctrl`, in the same clock domain, sharing its `strobe_100kHz`.

Parameters:
- TBL_AW, 8, table address width; table depth is 2**TBL_AW entries.
- SLAVE_ADDR, 7'h3C, 7-bit I2C device address driven on slave_address.
- TIMEOUT_STROBES, 200, strobe count after enable before a transaction is declared failed; must exceed the worst-case controller transaction (~120 strobes).
- MAX_RETRY, 2, re-issues of a failed entry before aborting.
- DELAY_UNIT, 100, strobes per delay tick (1 ms at 100 kHz).

Ports:
- clk  in  1  system clock
- areset_n  in  1  reset, synchronous, active-low
- strobe_100kHz  in  1  one-clk pulse at 100 kHz, same strobe that feeds i2c_ctrl
- start  in  1  one-clk pulse; starts the sequence from entry 0; ignored while busy
- busy  out  1  high from the accepted start until FINISH/FAIL
- seq_done  out  1  one-clk pulse on successful end of table
- seq_error  out  1  sticky; set on abort, cleared by next accepted start
- err_index  out  TBL_AW  index of the failing entry; valid while seq_error=1
- tbl_addr  out  TBL_AW  ROM read address
- tbl_data  in  16  ROM data; valid exactly 1 clk after tbl_addr changes
- enable  out  1  one-clk pulse to i2c_ctrl
- slave_address  out  7  constant SLAVE_ADDR
- register_address  out  16  entry payload; held stable from enable until completion
- register_done  in  1  i2c_ctrl completion level

Behaviour:
- Reset (clk edge with areset_n=0): state IDLE; busy=0, seq_done=0, seq_error=0, err_index=0, tbl_addr=0, enable=0, register_address=0, all counters 0. Reset mid-transaction abandons it; no enable is issued afterwards.
- Entry decode:
  - 16'hFFFF: end of table.
  - Upper byte 8'hFE: delay of low-byte × DELAY_UNIT strobes; low byte 0 means no delay.
  - Any other value: write transaction, register_address = entry.
- Reaching index 2**TBL_AW-1 without a terminator: that entry is processed, then the sequence ends as if the next entry were FFFF. tbl_addr does not wrap.
- States:
  - IDLE: on start → FETCH; index=0, retry=0, seq_error=0, busy=1.
  - FETCH: drive tbl_addr=index → WAIT_DATA.
  - WAIT_DATA: 1 clk → DECODE; latch tbl_data.
  - DECODE:
    - FFFF → FINISH.
    - FE-class → DELAY; load the counter.
    - Otherwise → ISSUE.
  - ISSUE: enable=1 for exactly 1 clk; clear the strobe counter; → WAIT_DONE.
  - WAIT_DONE:
    - Detect a rising edge of register_done (compare with a 1-clk delayed copy). i2c_ctrl drops register_done the clk after enable, so a stale high level from the previous entry never counts as completion.
    - On a rising edge: retry=0, index+1 → FETCH.
    - Count strobes; when the count equals TIMEOUT_STROBES:
      - retry<MAX_RETRY → retry+1 → ISSUE (same entry).
      - Otherwise → FAIL.
    - A rising edge and timeout expiry in the same clk count as success.
  - DELAY: decrement on each strobe; at 0 → index+1 → FETCH.
  - FINISH: seq_done pulse 1 clk, busy=0 → IDLE.
  - FAIL: seq_error=1, err_index=index, busy=0 → IDLE.
- Latency from start to the first enable: 4 clks (FETCH, WAIT_DATA, DECODE, ISSUE).
- Counters:
  - Strobe counter: sized $clog2(TIMEOUT_STROBES+1).
  - Delay counter: 8+$clog2(DELAY_UNIT) bits, or a nested tick/prescale pair.
  - Neither counter wraps; both saturate or reload only as specified.
- start asserted while busy: ignored, no effect.

Decomposition:
- Shared package i2c_pkg:
  - state enum.
  - ENTRY_END=16'hFFFF, ENTRY_DELAY_TAG=8'hFE.
  - Default TIMEOUT_STROBES.
  - Transaction-length constant shared with i2c_ctrl.
- One natural sub-module: i2c_strobe_timer, a loadable down-counter advanced by strobe_100kHz with a zero flag. It is used for both the timeout and the delay, instantiated once and time-shared because the two are never active together.

Test Plan:
- Table {1234, ABCD, FFFF} with a controller model ACKing everything → two enables with register_address 1234 then ABCD; seq_done pulse; seq_error=0; busy low after FINISH.
- Table {FE03, 5566, FFFF}, DELAY_UNIT=100 → first enable exactly 300 strobes (±1) after DECODE; register_address=5566.
- Entry 0 NACKed always, MAX_RETRY=2 → 3 enables spaced TIMEOUT_STROBES apart; then seq_error=1, err_index=0, no seq_done, entry 1 never issued.
- Entry 1 NACKed once then ACKed → 2 enables for entry 1; sequence completes; seq_error=0.
- start pulsed while busy, and reset asserted during WAIT_DONE → no restart from the start pulse; all outputs at reset values next clk; no further enable.
- TBL_AW=2, table with no FFFF → all 4 entries issued, then seq_done; tbl_addr never exceeds 3.
